// File: rtl/aha_deep_sleep_pkg.sv
// Shared types and widths for the deep-sleep controller and its cycle counter.
package aha_deep_sleep_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_WIC_REQ  = 3'd1,
        ST_HOLD_REQ = 3'd2,
        ST_SLEEP    = 3'd3,
        ST_WAKE_CLK = 3'd4,
        ST_WAKE_REL = 3'd5
    } sleep_state_e;

endpackage

// File: rtl/aha_sleep_cycle_counter.sv
// Counts cycles spent in the current state; done flags the last cycle before
// the count would reach limit, so a state lasts exactly limit cycles.
module aha_sleep_cycle_counter
    import aha_deep_sleep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = enable && (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/aha_deep_sleep_ctrl.sv
// Deep-sleep entry/exit sequencer (WIC handshake, CPU hold, clock gate).
// Optional handshake timeout enabled by defining AHA_DEEP_SLEEP_TIMEOUT_EN.
module aha_deep_sleep_ctrl
    import aha_deep_sleep_pkg::*;
#(
    parameter int WAKE_DELAY  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               MASTER_CLK,
    input  logic               PORESETn,
    input  logic               SLEEP,
    input  logic               SLEEPDEEP,
    input  logic               DBGPWRUPREQ,
    input  logic               PMU_WAKEUP,
    input  logic               PMU_WIC_EN_ACK,
    input  logic               SLEEPHOLDACKn,
    output logic               PMU_WIC_EN_REQ,
    output logic               SLEEPHOLDREQn,
    output logic               CPU_GCLK_EN,
    output logic               DEEP_SLEEPING,
    output logic [STATE_W-1:0] SLEEP_STATE,
    output logic               TIMEOUT_ERR
);

    sleep_state_e     state, next_state;
    logic             nxt_wic_req, nxt_hold_n, nxt_gclk_en, nxt_deep;
    logic             qualify, abort_req, timeout_hit;
    logic             cnt_clear, cnt_enable, cnt_done;
    logic [CNT_W-1:0] cnt_limit;

    assign qualify   = SLEEP & SLEEPDEEP & ~DBGPWRUPREQ & ~PMU_WAKEUP;
    assign abort_req = ~SLEEPDEEP | PMU_WAKEUP | DBGPWRUPREQ;

`ifdef AHA_DEEP_SLEEP_TIMEOUT_EN
    logic waiting;
    assign waiting     = (state == ST_WIC_REQ) || (state == ST_HOLD_REQ) ||
                         (state == ST_WAKE_REL);
    assign timeout_hit = waiting & cnt_done;
    assign cnt_enable  = waiting || (state == ST_WAKE_CLK);
`else
    assign timeout_hit = 1'b0;
    assign cnt_enable  = (state == ST_WAKE_CLK);
`endif

    // One counter serves both the wake delay and the handshake timeout.
    assign cnt_limit = (state == ST_WAKE_CLK) ? CNT_W'(WAKE_DELAY) : CNT_W'(ACK_TIMEOUT);
    assign cnt_clear = (next_state != state);

    aha_sleep_cycle_counter u_counter (
        .clk    (MASTER_CLK),
        .rst_n  (PORESETn),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .limit  (cnt_limit),
        .done   (cnt_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:      if (qualify) next_state = ST_WIC_REQ;
            ST_WIC_REQ: begin
                if (abort_req || timeout_hit) next_state = ST_WAKE_REL;
                else if (PMU_WIC_EN_ACK)      next_state = ST_HOLD_REQ;
            end
            ST_HOLD_REQ: begin
                if (abort_req || timeout_hit) next_state = ST_WAKE_REL;
                else if (!SLEEPHOLDACKn)      next_state = ST_SLEEP;
            end
            ST_SLEEP:    if (PMU_WAKEUP || DBGPWRUPREQ) next_state = ST_WAKE_CLK;
            ST_WAKE_CLK: if (cnt_done) next_state = ST_WAKE_REL;
            ST_WAKE_REL: if (timeout_hit || !PMU_WIC_EN_ACK) next_state = ST_RUN;
            default:     next_state = ST_RUN;
        endcase

        // Outputs are decoded from next_state so they register alongside it.
        nxt_wic_req = (next_state == ST_WIC_REQ) || (next_state == ST_HOLD_REQ) ||
                      (next_state == ST_SLEEP)   || (next_state == ST_WAKE_CLK);
        nxt_hold_n  = !((next_state == ST_HOLD_REQ) || (next_state == ST_SLEEP) ||
                        (next_state == ST_WAKE_CLK));
        nxt_gclk_en = (next_state != ST_SLEEP);
        nxt_deep    = (next_state == ST_SLEEP);
    end

    always_ff @(posedge MASTER_CLK) begin
        if (!PORESETn) begin
            state          <= ST_RUN;
            PMU_WIC_EN_REQ <= 1'b0;
            SLEEPHOLDREQn  <= 1'b1;
            CPU_GCLK_EN    <= 1'b1;
            DEEP_SLEEPING  <= 1'b0;
        end else begin
            state          <= next_state;
            PMU_WIC_EN_REQ <= nxt_wic_req;
            SLEEPHOLDREQn  <= nxt_hold_n;
            CPU_GCLK_EN    <= nxt_gclk_en;
            DEEP_SLEEPING  <= nxt_deep;
        end
    end

    assign SLEEP_STATE = state;

`ifdef AHA_DEEP_SLEEP_TIMEOUT_EN
    always_ff @(posedge MASTER_CLK) begin
        if (!PORESETn) begin
            TIMEOUT_ERR <= 1'b0;
        end else if (timeout_hit) begin
            TIMEOUT_ERR <= 1'b1;
        end
    end
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule
